// File: rtl/arb_pkg.sv
// Shared types for the memory port arbiter: FSM state encoding and owner tag.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the shared memory port.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
);

  logic          req_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] wdata_a;
  logic          we_a;
  logic          gnt_a;
  logic          done_a;

  logic          req_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] wdata_b;
  logic          we_b;
  logic          gnt_b;
  logic          done_b;

  logic          mem_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] rdata;

  // Arbiter view.
  modport slave (
    input  req_a, addr_a, wdata_a, we_a,
    input  req_b, addr_b, wdata_b, we_b,
    input  mem_ready, mem_rdata,
    output gnt_a, done_a, gnt_b, done_b,
    output mem_valid, mem_addr, mem_wdata, mem_we, rdata
  );

  // Requesters plus memory, as seen from outside the arbiter.
  modport master (
    output req_a, addr_a, wdata_a, we_a,
    output req_b, addr_b, wdata_b, we_b,
    output mem_ready, mem_rdata,
    input  gnt_a, done_a, gnt_b, done_b,
    input  mem_valid, mem_addr, mem_wdata, mem_we, rdata
  );

endinterface

// File: rtl/scale_mux.sv
// Two-way steering mux; sel_a_i picks a_i, otherwise b_i.
module scale_mux #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             sel_a_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = sel_a_i ? a_i : b_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the shared memory port; holds the grant for a whole
// transaction and hands over without a bubble when the other side is waiting.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic                 clk,
  input  logic                 rst_,
  mem_port_arbiter_if.slave    bus
);

  arb_state_t    state_q, state_d;
  owner_t        last_q, last_d;

  logic          gnt_a;
  logic          gnt_b;
  logic          mem_valid;
  logic [AW-1:0] mux_addr;
  logic [DW-1:0] mux_wdata;
  logic [0:0]    mux_we;

  // State register; last resets to B so A wins the first tie.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= IDLE;
      last_q  <= OWNER_B;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Next state; a completing owner's own req is ignored so it must re-arbitrate.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (bus.req_a && bus.req_b) begin
          state_d = (last_q == OWNER_A) ? GRANT_B : GRANT_A;
        end else if (bus.req_a) begin
          state_d = GRANT_A;
        end else if (bus.req_b) begin
          state_d = GRANT_B;
        end
      end
      GRANT_A: begin
        if (bus.mem_ready) begin
          last_d  = OWNER_A;
          state_d = bus.req_b ? GRANT_B : IDLE;
        end
      end
      GRANT_B: begin
        if (bus.mem_ready) begin
          last_d  = OWNER_B;
          state_d = bus.req_a ? GRANT_A : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grants decode straight from state so reset drops them immediately.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    case (state_q)
      GRANT_A: gnt_a = 1'b1;
      GRANT_B: gnt_b = 1'b1;
      default: ;
    endcase
  end

  assign mem_valid = gnt_a | gnt_b;

  scale_mux #(.WIDTH(AW)) u_addr_mux (
    .sel_a_i (gnt_a),
    .a_i     (bus.addr_a),
    .b_i     (bus.addr_b),
    .y_o     (mux_addr)
  );

  scale_mux #(.WIDTH(DW)) u_wdata_mux (
    .sel_a_i (gnt_a),
    .a_i     (bus.wdata_a),
    .b_i     (bus.wdata_b),
    .y_o     (mux_wdata)
  );

  scale_mux #(.WIDTH(1)) u_we_mux (
    .sel_a_i (gnt_a),
    .a_i     (bus.we_a),
    .b_i     (bus.we_b),
    .y_o     (mux_we)
  );

  assign bus.gnt_a     = gnt_a;
  assign bus.gnt_b     = gnt_b;
  assign bus.done_a    = gnt_a & bus.mem_ready;
  assign bus.done_b    = gnt_b & bus.mem_ready;
  assign bus.mem_valid = mem_valid;
  assign bus.mem_addr  = mux_addr;
  assign bus.mem_wdata = mux_wdata;
  assign bus.mem_we    = mux_we[0] & mem_valid;
  assign bus.rdata     = bus.mem_rdata;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single shared memory port. Requester A (instruction fetch) and requester B (load/store) each present a request with address, write data and write enable. The block grants one requester at a time with round-robin fairness and holds the grant for the whole memory transaction. It drives the select line of internal `scale_mux` instances that steer the granted requester's payload onto the port.

## Interface
Parameters:
- `AW`, default 8: address width.
- `DW`, default 8: data width.

Ports:
- `clk` input 1: system clock, rising edge.
- `rst_` input 1: asynchronous, active-low reset.
- `req_a` input 1: requester A transaction request; held until `done_a`.
- `addr_a` input AW: requester A address.
- `wdata_a` input DW: requester A write data.
- `we_a` input 1: requester A write enable (1 = write).
- `gnt_a` output 1: A currently owns the port.
- `done_a` output 1: A's transaction completes this cycle.
- `req_b`, `addr_b`, `wdata_b`, `we_b`, `gnt_b`, `done_b`: same as above, for requester B.
- `mem_valid` output 1: port transaction active.
- `mem_addr` output AW: muxed address.
- `mem_wdata` output DW: muxed write data.
- `mem_we` output 1: muxed write enable, gated by `mem_valid`.
- `mem_ready` input 1: memory completes the transaction in this cycle.
- `mem_rdata` input DW: read data, valid with `mem_ready`.
- `rdata` output DW: `mem_rdata` passed through to both requesters.

## Operation
- FSM states: `IDLE`, `GRANT_A`, `GRANT_B`. State and the `last` register are flopped.
- `last` records the last granted requester and resets to B, so A wins the first tie.
- `IDLE` transitions:
  - only `req_a` → `GRANT_A`.
  - only `req_b` → `GRANT_B`.
  - both → grant the requester other than `last`.
  - neither → stay in `IDLE`.
- `GRANT_x` with `mem_ready`=0: hold the grant. Wait states are unbounded.
- `GRANT_x` with `mem_ready`=1 (completion):
  - `last` ← x.
  - If the other requester's req is high, go directly to `GRANT_other` with no idle bubble. Otherwise go to `IDLE`.
  - The completing requester's own req is ignored on this edge. It re-arbitrates from `IDLE`, which prevents back-to-back monopoly.
- Outputs, all combinational from state:
  - `gnt_a` = (state==`GRANT_A`); `gnt_b` = (state==`GRANT_B`).
  - `mem_valid` = `gnt_a` | `gnt_b`.
  - mux select = `gnt_a`. In `IDLE`, B's fields pass through, but `mem_valid`=0.
  - `mem_we` = selected we & `mem_valid`.
  - `done_x` = `gnt_x` & `mem_ready`.
  - `rdata` = `mem_rdata`, unregistered.
- Requester protocol: hold req and payload stable from assertion until the `done_x` cycle. Drop req, or present a new request, after that edge.
- Requester protocol violation: if req drops while granted, the grant is still held until `mem_ready`. The arbiter never aborts a transaction.

## Timing
- Reset (asynchronous assert): state=`IDLE`, `last`=B. All outputs are 0 except the mux-driven `mem_addr`, `mem_wdata` and `rdata`, which follow their inputs. Reset asserted mid-transaction drops the grant immediately.
- Request-to-grant latency: 1 cycle. A req sampled high in `IDLE` at edge N gives `gnt` and `mem_valid` high after edge N.
- Completion: `done_x` is high in the same cycle as `mem_ready`. The grant deasserts, or switches, on the following edge.
- Back-to-back, other requester pending: 0 idle cycles between transactions.
- Same requester repeating: at least 1 `IDLE` cycle between transactions.
- `mem_ready` sampled in `IDLE` is ignored.

## Structure
- Shared package `arb_pkg`:
  - `typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} arb_state_t`.
  - `typedef enum logic {OWNER_A, OWNER_B} owner_t`, used for `last`.
- Sub-module: `scale_mux`, instantiated three times with `sel_a`=`gnt_a`:
  - WIDTH=AW for address.
  - WIDTH=DW for write data.
  - WIDTH=1 for write enable.
- The FSM and `last` register live in this module.

## Test plan
- Reset mid-transaction: with A granted, pull `rst_` low → same cycle `gnt_a`=0, `mem_valid`=0. After release, `req_b`=1 alone → `gnt_b`=1 one cycle later.
- Single read by A: `req_a`=1, `addr_a`=8'h3C, `we_a`=0. Memory asserts `mem_ready` 2 cycles after `mem_valid`, with `mem_rdata`=8'hA5.
  - Expect `mem_addr`=8'h3C and `mem_we`=0 while granted.
  - Expect `done_a`=1 and `rdata`=8'hA5 in the ready cycle.
  - Expect `IDLE` next cycle.
- Tie after reset, then back-to-back: `req_a` and `req_b` rise together, `mem_ready` tied high.
  - A is granted first; B follows with 0 idle cycles.
  - A re-requests immediately → the next tie goes to A, since `last`=B.
- Write by B: `addr_b`=8'h10, `wdata_b`=8'h7E, `we_b`=1 → `mem_we`=1 and `mem_wdata`=8'h7E while granted. `mem_we`=0 in every `IDLE` cycle.
- Fairness under saturation: both reqs held high for 20 transactions with `mem_ready`=1 → grants strictly alternate A, B, A, B, … with no `IDLE` cycle.
